// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a variable-latency data memory.
// One request in flight; alignment checked at accept; ACCESS aborts after TIMEOUT ack-less cycles.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        we_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;

    logic        mem_en_q, mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic        resp_valid_q, resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        aligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] rdata_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        aligned = 1'b0;
        be_d    = 4'b0000;
        wdata_d = req_wdata;
        case (req_size)
            2'b00: begin
                aligned = 1'b1;
                be_d    = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                aligned = ~req_addr[0];
                be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                aligned = (req_addr[1:0] == 2'b00);
                be_d    = 4'b1111;
            end
            default: ;
        endcase
    end

    // Lane selection and extension of the returned word, using the latched request fields.
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   rdata_d = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   rdata_d = {{16{signed_q & ld_half[15]}}, ld_half};
            default: rdata_d = mem_rdata;
        endcase
        if (we_q) begin
            rdata_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (req_valid) begin
                        we_q     <= req_we;
                        signed_q <= req_signed;
                        size_q   <= req_size;
                        lane_q   <= req_addr[1:0];
                        cnt_q    <= '0;
                        if (aligned) begin
                            state_q     <= S_ACCESS;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_be_q    <= be_d;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                        end else begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack in the final allowed cycle takes priority over the timeout.
                    if (mem_ack) begin
                        state_q      <= S_RESP;
                        mem_en_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= rdata_d;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q      <= S_RESP;
                        mem_en_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = reset && (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus random accesses
// compared against an arithmetic reference of alignment, lanes, extension and timeout.
module tb_dmem_access_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one request from the idle drive point (just after a rising edge) back to the next one.
    // ack_after = cycle of mem_en on which the memory acks (0 or > TO means it never does).
    task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                             input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_after, input logic [31:0] rdata);
        logic        err;
        logic        tmo;
        logic [31:0] exp_be, exp_wd, exp_rd, v;
        int          lane, n_en;
        lane   = int'(addr[1:0]);
        err    = 1'b0;
        exp_be = 0;
        exp_wd = wdata;
        exp_rd = rdata;
        case (size)
            2'd0: begin
                exp_be = 32'd1 << lane;
                exp_wd = {24'd0, wdata[7:0]} * 32'h0101_0101;
                v = (rdata >> (8 * lane)) & 32'hFF;
                if (sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
                exp_rd = v;
            end
            2'd1: begin
                err    = addr[0];
                exp_be = addr[1] ? 32'd12 : 32'd3;
                exp_wd = {16'd0, wdata[15:0]} * 32'h0001_0001;
                v = (rdata >> (addr[1] ? 16 : 0)) & 32'hFFFF;
                if (sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
                exp_rd = v;
            end
            2'd2: begin
                err    = (addr[1:0] != 2'b00);
                exp_be = 32'd15;
            end
            default: err = 1'b1;
        endcase
        tmo  = !(ack_after >= 1 && ack_after <= TO);
        n_en = tmo ? TO : ack_after;
        if (we || err || tmo) exp_rd = 0;

        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        check({tag, " req_ready before accept"}, req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (!err) begin
            for (int c = 1; c <= n_en; c++) begin
                mem_ack   = (c == ack_after);
                mem_rdata = (c == ack_after) ? rdata : $urandom;
                @(negedge clk);
                check($sformatf("%s mem_en cycle %0d", tag, c), mem_en, 1);
                if (c == 1) begin
                    check({tag, " mem_we"}, mem_we, we);
                    check({tag, " mem_be"}, mem_be, exp_be);
                    check({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                    if (we) check({tag, " mem_wdata"}, mem_wdata, exp_wd);
                    check({tag, " busy in access"}, busy, 1);
                    check({tag, " resp_valid in access"}, resp_valid, 0);
                end
                @(posedge clk);
                #1;
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end
        @(negedge clk);
        check({tag, " resp_valid"}, resp_valid, 1);
        check({tag, " resp_err"}, resp_err, err | tmo);
        check({tag, " resp_rdata"}, resp_rdata, exp_rd);
        check({tag, " mem_en in resp"}, mem_en, 0);
        check({tag, " busy in resp"}, busy, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, " resp_valid after resp"}, resp_valid, 0);
        check({tag, " req_ready after resp"}, req_ready, 1);
        check({tag, " resp_rdata held"}, resp_rdata, exp_rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset mem_en", mem_en, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_be", mem_be, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_rdata", resp_rdata, 0);
        check("reset resp_err", resp_err, 0);
        check("reset req_ready", req_ready, 0);
        check("reset busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: signed half load, upper half
        do_access("t1", 1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0, 1, 32'h8001_7FFF);
        // 2: byte store to lane 3, ack on the fourth cycle
        do_access("t2", 1'b1, 2'b00, 1'b0, 32'h0000_2003, 32'h0000_00A5, 4, 32'h1234_5678);
        // 3: misaligned word, then illegal size
        do_access("t3a", 1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0, 1, 32'hDEAD_BEEF);
        do_access("t3b", 1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0, 1, 32'hDEAD_BEEF);
        // 4: timeout, then a late ack while idle
        do_access("t4", 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 0, 32'hCAFE_F00D);
        mem_ack = 1'b1;
        @(negedge clk);
        check("t4 late ack resp_valid", resp_valid, 0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("t4 late ack resp_valid next", resp_valid, 0);
        check("t4 late ack busy", busy, 0);
        check("t4 late ack mem_en", mem_en, 0);
        @(posedge clk);
        #1;

        // 5: reset in the middle of an access
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h0000_5000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("t5 mem_en before reset", mem_en, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5 req_ready reset low", req_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5 mem_en after reset", mem_en, 0);
        check("t5 mem_be after reset", mem_be, 0);
        check("t5 mem_addr after reset", mem_addr, 0);
        check("t5 resp_valid after reset", resp_valid, 0);
        check("t5 resp_err after reset", resp_err, 0);
        check("t5 busy after reset", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("t5 req_ready after release", req_ready, 1);
        check("t5 resp_valid after release", resp_valid, 0);
        @(posedge clk);
        #1;
        do_access("t5 byte", 1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0, 2, 32'h0000_F000);

        // 6: req_valid held high across two word loads
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h0000_6000;
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        @(negedge clk);
        check("t6 first mem_addr", mem_addr, 32'h0000_6000);
        check("t6 req_ready in access", req_ready, 0);
        check("t6 busy in access", busy, 1);
        @(posedge clk);
        #1;
        mem_ack  = 1'b0;
        req_addr = 32'h0000_6004;
        @(negedge clk);
        check("t6 first resp_rdata", resp_rdata, 32'h1111_2222);
        check("t6 busy in resp", busy, 1);
        check("t6 req_ready in resp", req_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t6 idle between", req_ready, 1);
        check("t6 no mem_en in idle", mem_en, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h3333_4444;
        @(negedge clk);
        check("t6 second mem_addr", mem_addr, 32'h0000_6004);
        check("t6 second mem_en", mem_en, 1);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("t6 second resp_valid", resp_valid, 1);
        check("t6 second resp_rdata", resp_rdata, 32'h3333_4444);
        @(posedge clk);
        #1;

        // Random accesses against the reference
        for (int i = 0; i < 40; i++) begin
            do_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                      $urandom, int'($urandom_range(0, TO + 2)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every load/store between the MEM pipeline stage and a variable-latency data memory.
- Accepts one request at a time and checks alignment.
- Drives the memory with a word address, byte enables and lane-replicated write data, waiting for an acknowledge, with a timeout.
- Returns a one-cycle response carrying sign/zero-extended load data or an error flag. The pipeline stalls on `busy`.

Parameters:
TIMEOUT  255  max cycles in ACCESS without mem_ack before aborting with error (1..65535)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  pipeline presents an access
req_ready  out  1  controller can accept (state IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  load extension: 1 sign, 0 zero
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
mem_en  out  1  memory access strobe, held until ack/timeout
mem_we  out  1  write strobe, valid with mem_en
mem_be  out  4  byte enables, bit i = byte lane i (bits [8i+7:8i])
mem_addr  out  32  {req_addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word, sampled on mem_ack
mem_ack  in  1  memory completion, one cycle
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned/illegal/timeout, valid with resp_valid
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE and the timeout counter clears.
  - All registered outputs are 0: mem_en, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_err.
  - req_ready is forced to 0 while reset is low.
  - A reset mid-ACCESS aborts the access with no response. The memory must tolerate mem_en dropping.
- States:
  - IDLE: req_ready=1, busy=0.
  - ACCESS: mem_en=1, busy=1.
  - RESP: resp_valid=1, busy=1.
- Accept happens on req_valid && req_ready at an edge. addr, we, size, signed and wdata are latched.
- Alignment check at accept:
  - half requires addr[0]==0.
  - word requires addr[1:0]==00.
  - size 11 is always illegal.
  - On violation: go to RESP with resp_err=1 and resp_rdata=0. mem_en never asserts.
- Legal request: go to ACCESS, with mem_* registered from the latched fields.
- Byte enables:
  - byte: be = 1 << addr[1:0].
  - half: be = addr[1] ? 1100 : 0011.
  - word: be = 1111.
  - Loads drive the same be; the memory may ignore it.
- Write data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- ACCESS:
  - The counter increments each cycle without mem_ack.
  - mem_ack: capture the response and go to RESP with err=0. mem_en deasserts in RESP.
  - Timeout: counter reaches TIMEOUT (TIMEOUT cycles with mem_en high and no ack) → go to RESP with err=1 and rdata=0.
  - mem_ack arriving in that same final cycle wins: normal completion.
- Load data extraction:
  - byte lane = addr[1:0]; half = addr[1] ? [31:16] : [15:0].
  - Extension is sign or zero per req_signed. Word loads ignore req_signed.
  - Store responses return rdata=0.
- RESP lasts exactly one cycle, then IDLE. resp_rdata/resp_err hold their value until the next RESP; resp_valid is 0 outside RESP.
- Minimum latency:
  - Accept at edge N; mem_en high in cycle N+1.
  - With ack in N+1, resp_valid in N+2 and req_ready in N+3.
  - Misaligned: resp_valid in N+1.
- mem_ack outside ACCESS is ignored. req_valid while busy is not accepted (req_ready=0); the pipeline holds its request.

Test Plan:
1. Signed half load, addr=0x1002, mem_rdata=0x8001_7FFF, ack 1 cycle after mem_en → mem_addr=0x1000, be=1100, resp_rdata=0xFFFF_8001, err=0, resp_valid 2 cycles after accept.
2. Byte store, addr=0x2003, wdata=0x0000_00A5, ack after 4 cycles → mem_we=1, be=1000, mem_wdata=0xA5A5_A5A5, mem_en high exactly 4 cycles, resp_rdata=0.
3. Word load at addr=0x3002, then size=11 at 0x3000 → each gives resp_err=1 in the cycle after accept, with mem_en never asserted.
4. TIMEOUT=8, load with no ack → mem_en high 8 cycles, then resp_err=1, rdata=0; a late mem_ack in IDLE produces no response.
5. reset=0 during ACCESS, then release → all outputs 0, no resp_valid; req_ready=1 the first cycle after release; next unsigned byte load at 0x11 with rdata=0x0000_F000 returns 0x0000_00F0.
6. Back-to-back req_valid held high for two word loads → second accepted only in IDLE after the first RESP; busy never drops between accept and RESP.
